// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
//   Instruction fetch unit. Owns the program counter, issues one single-beat
//   64-bit AXI read at a time, and presents each fetched 32-bit instruction
//   (with its PC and an error flag) to the if_id stage. Redirects retarget the
//   PC at any time; a response already in flight when a redirect arrives is
//   consumed and thrown away.
//
//   Handshakes: every channel uses strict valid/ready semantics. A transfer
//   happens on a rising edge where both valid and ready are high. A source
//   never drops valid or changes its payload until that transfer happens,
//   except if_inst_valid, which a redirect may withdraw.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   redirect_valid/_pc   branch/jump/trap redirect and its target
//   stall                blocks launching a new read request
//   if_pc, if_inst       buffered instruction and its PC
//   if_inst_valid/ready  handshake towards if_id
//   fetch_err            buffered instruction returned a non-OKAY response
//   axi_ar_*             AXI read address channel (size fixed at 8 bytes)
//   axi_r_*              AXI read data channel (single beat)
//   dbg_state            current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 HOLD)
// -----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        stall,
   output logic [63:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_inst_valid,
   input  logic        if_inst_ready,
   output logic        fetch_err,
   output logic        axi_ar_valid,
   input  logic        axi_ar_ready,
   output logic [63:0] axi_ar_addr,
   output logic [2:0]  axi_ar_size,
   input  logic        axi_r_valid,
   output logic        axi_r_ready,
   input  logic [63:0] axi_r_data,
   input  logic [1:0]  axi_r_resp,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q;
   logic [63:0] pc_q;
   logic [63:0] pc_d;
   logic [63:0] ar_addr_q;
   logic        drop_q;
   logic        ar_valid_q;
   logic        r_ready_q;
   logic [63:0] if_pc_q;
   logic [31:0] if_inst_q;
   logic        valid_q;
   logic        err_q;

   // Next fetch address: a redirect always wins over the sequential advance.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (state_q == S_HOLD && if_inst_ready) begin
         pc_d = pc_q + 64'd4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ar_addr_q  <= 64'd0;
         drop_q     <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         if_pc_q    <= 64'd0;
         if_inst_q  <= 32'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            S_IDLE: begin
               if (!stall) begin
                  // A redirect arriving in IDLE is fetched directly, so the
                  // old sequential PC is never requested.
                  ar_addr_q  <= redirect_valid ? redirect_pc : pc_q;
                  ar_valid_q <= 1'b1;
                  state_q    <= S_ADDR;
               end
            end
            S_ADDR: begin
               // The address stays put until accepted; a redirect only marks
               // the eventual response as stale.
               if (redirect_valid) begin
                  drop_q <= 1'b1;
               end
               if (axi_ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= S_DATA;
               end
            end
            S_DATA: begin
               if (axi_r_valid) begin
                  r_ready_q <= 1'b0;
                  // A redirect on the same cycle as the beat counts as drop.
                  if (drop_q || redirect_valid) begin
                     drop_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     if_inst_q <= ar_addr_q[2] ? axi_r_data[63:32] : axi_r_data[31:0];
                     if_pc_q   <= ar_addr_q;
                     err_q     <= (axi_r_resp != 2'b00);
                     valid_q   <= 1'b1;
                     state_q   <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  drop_q <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect_valid || if_inst_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign if_pc         = if_pc_q;
   assign if_inst       = if_inst_q;
   assign if_inst_valid = valid_q;
   assign fetch_err     = err_q;
   assign axi_ar_valid  = ar_valid_q;
   assign axi_ar_addr   = ar_addr_q;
   assign axi_ar_size   = 3'b011;
   assign axi_r_ready   = r_ready_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
//   Bench for if_fetch. A behavioural AXI slave serves a synthetic instruction
//   memory; the reference model tracks only the architectural rule "the next
//   delivered instruction is the one at the current PC", where the PC advances
//   by 4 on accept and jumps on redirect.
// -----------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        stall;
   logic [63:0] if_pc;
   logic [31:0] if_inst;
   logic        if_inst_valid;
   logic        if_inst_ready;
   logic        fetch_err;
   logic        axi_ar_valid;
   logic        axi_ar_ready;
   logic [63:0] axi_ar_addr;
   logic [2:0]  axi_ar_size;
   logic        axi_r_valid;
   logic        axi_r_ready;
   logic [63:0] axi_r_data;
   logic [1:0]  axi_r_resp;
   logic [1:0]  dbg_state;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .if_inst_valid  (if_inst_valid),
      .if_inst_ready  (if_inst_ready),
      .fetch_err      (fetch_err),
      .axi_ar_valid   (axi_ar_valid),
      .axi_ar_ready   (axi_ar_ready),
      .axi_ar_addr    (axi_ar_addr),
      .axi_ar_size    (axi_ar_size),
      .axi_r_valid    (axi_r_valid),
      .axi_r_ready    (axi_r_ready),
      .axi_r_data     (axi_r_data),
      .axi_r_resp     (axi_r_resp),
      .dbg_state      (dbg_state)
   );

   // ---------------- memory image ----------------
   function automatic logic [31:0] word_at(input logic [63:0] a);
      logic [63:0] w;
      w = {a[63:2], 2'b00};
      if (w == 64'h8000_0000) return 32'h0010_0093;
      if (w == 64'h8000_0004) return 32'h0000_0013;
      return w[31:0] ^ {w[63:48], w[15:0]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic err_for(input logic [63:0] a);
      return (a[7:3] == 5'h1F);
   endfunction

   // ---------------- scoreboard state ----------------
   logic [63:0] exp_q[$];
   logic [63:0] cur_pc;
   bit          seen;
   int          checks;
   int          errors;
   int          n_deliv;
   int          wd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- AXI slave ----------------
   int          ar_dly;
   int          r_dly;
   bit          rand_slave;
   int          ar_cnt;
   int          r_cnt;
   bit          pend;
   logic [63:0] pend_addr;
   logic        ar_hs;
   logic        r_hs;
   logic [63:0] hs_addr;

   initial begin
      axi_ar_ready = 1'b0;
      axi_r_valid  = 1'b0;
      axi_r_data   = 64'd0;
      axi_r_resp   = 2'b00;
      pend = 0; ar_cnt = 0; r_cnt = 0; pend_addr = 64'd0;
      forever begin
         @(posedge clk);
         ar_hs   = axi_ar_valid && axi_ar_ready;
         r_hs    = axi_r_valid && axi_r_ready;
         hs_addr = axi_ar_addr;
         #1;
         if (rst) begin
            axi_ar_ready = 1'b0;
            axi_r_valid  = 1'b0;
            pend = 0; ar_cnt = 0;
         end else begin
            if (r_hs) axi_r_valid = 1'b0;
            if (ar_hs) begin
               axi_ar_ready = 1'b0;
               ar_cnt       = 0;
               pend         = 1;
               pend_addr    = hs_addr;
               r_cnt        = rand_slave ? int'($urandom_range(0, 3)) : r_dly;
               if (rand_slave) ar_dly = $urandom_range(0, 3);
            end else if (axi_ar_valid && !axi_ar_ready) begin
               if (ar_cnt >= ar_dly) axi_ar_ready = 1'b1;
               else ar_cnt++;
            end
            if (pend && !axi_r_valid) begin
               if (r_cnt == 0) begin
                  axi_r_valid = 1'b1;
                  axi_r_data  = {word_at({pend_addr[63:3], 3'b000} + 64'd4),
                                 word_at({pend_addr[63:3], 3'b000})};
                  axi_r_resp  = err_for(pend_addr) ? 2'b10 : 2'b00;
                  pend        = 0;
               end else begin
                  r_cnt--;
               end
            end
         end
      end
   end

   // ---------------- reference model update (on edges) ----------------
   always @(posedge clk) begin
      if (!rst) begin
         if (redirect_valid) begin
            exp_q.delete();
            exp_q.push_back(redirect_pc);
            seen = 0;
         end else if (if_inst_valid && if_inst_ready) begin
            exp_q.push_back(cur_pc + 64'd4);
            seen = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         wd++;
         if (wd > 400) begin
            check("watchdog_no_delivery", 64'd1, 64'd0);
            wd = 0;
         end
         if (if_inst_valid && !seen) begin
            seen = 1;
            wd   = 0;
            n_deliv++;
            if (exp_q.size() == 0) begin
               check("unexpected_delivery_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               cur_pc = exp_q.pop_front();
               check("if_pc", if_pc, cur_pc);
               check("if_inst", {32'd0, if_inst}, {32'd0, word_at(cur_pc)});
               check("fetch_err", {63'd0, fetch_err}, {63'd0, err_for(cur_pc)});
            end
         end else if (seen) begin
            check("hold_valid", {63'd0, if_inst_valid}, 64'd1);
            if (if_inst_valid) begin
               check("hold_pc", if_pc, cur_pc);
               check("hold_inst", {32'd0, if_inst}, {32'd0, word_at(cur_pc)});
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_deliv(input int target);
      int t;
      t = 0;
      while (n_deliv < target && t < 300) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      check("delivery_arrived", {63'd0, n_deliv >= target}, 64'd1);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      @(negedge clk);
      while (!if_inst_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("valid_arrived", {63'd0, if_inst_valid}, 64'd1);
   endtask

   task automatic wait_ar_hs(output logic [63:0] addr);
      int t;
      t = 0;
      @(posedge clk);
      while (!(axi_ar_valid && axi_ar_ready) && t < 300) begin
         @(posedge clk);
         t++;
      end
      addr = axi_ar_addr;
      check("ar_handshake_arrived", {63'd0, axi_ar_valid && axi_ar_ready}, 64'd1);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_if_pc", if_pc, 64'd0);
      check("rst_if_inst", {32'd0, if_inst}, 64'd0);
      check("rst_if_inst_valid", {63'd0, if_inst_valid}, 64'd0);
      check("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
      check("rst_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
      check("rst_ar_addr", axi_ar_addr, 64'd0);
      check("rst_r_ready", {63'd0, axi_r_ready}, 64'd0);
   endtask

   task automatic redirect_to(input logic [63:0] target);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [63:0] a;
   int          n;
   int          base;

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0; stall = 1'b0;
      if_inst_ready = 1'b1; ar_dly = 0; r_dly = 0; rand_slave = 0;
      checks = 0; errors = 0; n_deliv = 0; wd = 0; seen = 0; cur_pc = 64'd0;
      exp_q.push_back(RESET_PC);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs();
      check("ar_size", {61'd0, axi_ar_size}, 64'd3);
      @(negedge clk);
      #2 rst = 1'b0;

      // First fetch after reset: AR at cycle 1, instruction by cycle 4.
      @(negedge clk);
      check("first_ar_valid", {63'd0, axi_ar_valid}, 64'd1);
      check("first_ar_addr", axi_ar_addr, RESET_PC);
      n = 1;
      while (!if_inst_valid && n < 4) begin
         @(negedge clk);
         n++;
      end
      check("first_valid_by_cycle4", {63'd0, if_inst_valid}, 64'd1);
      wait_deliv(2);

      // Back-pressure: held for 5 cycles, buffer must stay put.
      step();
      if_inst_ready = 1'b0;
      wait_valid();
      repeat (5) step();
      if_inst_ready = 1'b1;
      wait_deliv(n_deliv + 1);

      // Redirect while in DATA with a slow response: the beat is dropped.
      r_dly = 3;
      wait_ar_hs(a);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      step();
      redirect_valid = 1'b0;
      r_dly = 0;
      wait_ar_hs(a);
      check("redirect_data_next_ar", a, 64'h8000_0100);

      // Redirect on the accept cycle: redirect target wins over pc+4.
      wait_valid();
      if_inst_ready  = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      wait_ar_hs(a);
      check("redirect_accept_next_ar", a, 64'h8000_0200);

      // Stall in IDLE keeps AR quiet.
      wait_valid();
      stall = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("stall_idle_no_ar", {63'd0, axi_ar_valid}, 64'd0);
      end
      stall = 1'b0;

      // Stall raised during ADDR with a slow ar_ready: request still completes.
      ar_dly = 3;
      n = 0;
      @(negedge clk);
      while (!axi_ar_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      base  = n_deliv;
      stall = 1'b1;
      wait_deliv(base + 1);
      stall  = 1'b0;
      ar_dly = 0;

      // Error response flagged alongside the instruction.
      if_inst_ready = 1'b0;
      redirect_to(64'h8000_00F8);
      base = n_deliv;
      wait_deliv(base + 1);
      check("err_flag", {63'd0, fetch_err}, 64'd1);
      check("err_pc", if_pc, 64'h8000_00F8);
      if_inst_ready = 1'b1;

      // 64-bit wraparound of the PC.
      redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
      base = n_deliv;
      wait_deliv(base + 2);

      // Asynchronous reset in the middle of DATA.
      r_dly = 3;
      wait_ar_hs(a);
      #3 rst = 1'b1;
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      seen = 0;
      wd   = 0;
      #1;
      check_reset_outputs();
      @(negedge clk);
      #2 rst = 1'b0;
      r_dly = 0;
      base = n_deliv;
      wait_deliv(base + 2);

      // Randomised traffic against the model.
      rand_slave = 1;
      for (int i = 0; i < 2000; i++) begin
         step();
         if_inst_ready = ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) begin
            redirect_valid = 1'b1;
            if ($urandom_range(0, 7) == 0)
               redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + {60'd0, 2'($urandom_range(0, 3)), 2'b00};
            else
               redirect_pc = 64'h8000_0000 + {54'd0, 8'($urandom_range(0, 255)), 2'b00};
         end else begin
            redirect_valid = 1'b0;
         end
      end
      step();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      if_inst_ready  = 1'b1;
      repeat (20) step();
      check("min_deliveries", {63'd0, n_deliv > 150}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      check("global_timeout", 64'd1, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
